// File: rtl/fifo_1d_22to64.sv
// Reassembles 22-bit link chunks into 64-bit words (3-chunk long, 2-chunk short)
// and holds each finished word in a one-entry output register.
module fifo_1d_22to64 (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] a_data,
  input  logic        a_short,
  input  logic        a_valid,
  output logic        a_ready,
  output logic [63:0] b_data,
  output logic        b_short,
  output logic        b_valid,
  input  logic        b_ready
);

  typedef enum logic [1:0] {
    C0 = 2'd0,
    C1 = 2'd1,
    C2 = 2'd2
  } cnt_e;

  cnt_e        r_cnt;
  logic        r_tgt_short;
  logic [43:0] r_acc;
  logic [63:0] r_b_data;
  logic        r_b_short;
  logic        r_b_valid;

  cnt_e        w_cnt_nxt;
  logic        w_tgt_nxt;
  logic [43:0] w_acc_nxt;
  logic [63:0] w_bd_nxt;
  logic        w_bs_nxt;
  logic        w_bv_nxt;
  logic        w_final;
  logic        w_take;

  // Only the word-completing chunk needs room in the output register.
  assign w_final = ((r_cnt == C1) && r_tgt_short) || (r_cnt == C2);
  assign a_ready = !w_final || !r_b_valid || b_ready;
  assign w_take  = a_valid && a_ready;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_tgt_nxt = r_tgt_short;
    w_acc_nxt = r_acc;
    w_bd_nxt  = r_b_data;
    w_bs_nxt  = r_b_short;
    w_bv_nxt  = r_b_valid;
    if (r_b_valid && b_ready) begin
      w_bv_nxt = 1'b0;
    end
    if (w_take) begin
      unique case (r_cnt)
        C0: begin
          w_tgt_nxt = a_short;
          // Long words keep only the 20 payload bits; the pad bits are dropped.
          w_acc_nxt[43:22] = a_short ? a_data
                                     : {2'b00, a_data[19:0]};
          w_cnt_nxt = C1;
        end
        C1: begin
          if (r_tgt_short) begin
            w_bd_nxt  = {20'h0, r_acc[43:22], a_data};
            w_bs_nxt  = 1'b1;
            w_bv_nxt  = 1'b1;
            w_cnt_nxt = C0;
          end else begin
            w_acc_nxt[21:0] = a_data;
            w_cnt_nxt = C2;
          end
        end
        C2: begin
          w_bd_nxt  = {r_acc[41:22], r_acc[21:0], a_data};
          w_bs_nxt  = 1'b0;
          w_bv_nxt  = 1'b1;
          w_cnt_nxt = C0;
        end
        default: begin
          w_cnt_nxt = C0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= C0;
      r_tgt_short <= 1'b0;
      r_acc       <= '0;
      r_b_data    <= '0;
      r_b_short   <= 1'b0;
      r_b_valid   <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_tgt_short <= w_tgt_nxt;
      r_acc       <= w_acc_nxt;
      r_b_data    <= w_bd_nxt;
      r_b_short   <= w_bs_nxt;
      r_b_valid   <= w_bv_nxt;
    end
  end

  assign b_data  = r_b_data;
  assign b_short = r_b_short;
  assign b_valid = r_b_valid;

endmodule
